// File: rtl/song_sequencer_if.sv
// Bus between the song sequencer, its note ROM and the player controls.
// The sequencer owns rom_addr and the audio/status outputs; the environment owns the rest.
interface song_sequencer_if #(
  parameter int ADDR_W = 5
);
  logic              start;
  logic              stop;
  logic              pause;
  logic              loop_en;
  logic [ADDR_W-1:0] rom_addr;
  logic [7:0]        rom_data;
  logic              speaker_out;
  logic              busy;
  logic [ADDR_W-1:0] note_idx;
  logic              done;
  logic [2:0]        state_dbg;

  // No valid/ready pair: start/stop are single-cycle pulses, pause/loop_en are levels,
  // and rom_data must hold the word at rom_addr exactly one cycle after rom_addr changes.
  modport master (
    output start, stop, pause, loop_en, rom_data,
    input  rom_addr, speaker_out, busy, note_idx, done, state_dbg
  );

  modport slave (
    input  start, stop, pause, loop_en, rom_data,
    output rom_addr, speaker_out, busy, note_idx, done, state_dbg
  );
endinterface

// File: rtl/song_sequencer.sv
// Table-driven melody player: fetches pitch/length words from a note ROM,
// generates the square-wave tone, holds it for N tempo ticks and inserts a silent gap.
module song_sequencer #(
  parameter int TICK_DIV = 3000000,
  parameter int GAP_CYC  = 240000,
  parameter int ADDR_W   = 5,
  parameter int SONG_MAX = 32
) (
  input  logic            clk,
  input  logic            rst,
  song_sequencer_if.slave bus
);

  localparam int PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int GAP_W   = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);
  localparam logic [GAP_W-1:0]   GAP_LAST   = GAP_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
  // One extra address bit so SONG_MAX == 2**ADDR_W is still reachable.
  localparam logic [ADDR_W:0]    ADDR_END   = (ADDR_W + 1)'(SONG_MAX);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_PLAY  = 3'd3,
    S_GAP   = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t             state_q;
  logic [ADDR_W:0]    addr_q;
  logic [ADDR_W-1:0]  note_idx_q;
  logic [3:0]         ticks_q;
  logic [PRESC_W-1:0] presc_q;
  logic [14:0]        tone_q;
  logic [14:0]        half_q;
  logic [GAP_W-1:0]   gap_q;
  logic               phase_q;
  logic               spk_q;
  logic               busy_q;
  logic               done_q;

  // Half-period in clk cycles at 12 MHz; zero marks a rest.
  function automatic logic [14:0] half_period(input logic [3:0] pitch);
    case (pitch)
      4'd1:    return 15'd22989;
      4'd2:    return 15'd20478;
      4'd3:    return 15'd18237;
      4'd4:    return 15'd17192;
      4'd5:    return 15'd15345;
      4'd6:    return 15'd13636;
      4'd7:    return 15'd12876;
      4'd8:    return 15'd11472;
      default: return 15'd0;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      note_idx_q <= '0;
      ticks_q    <= '0;
      presc_q    <= '0;
      tone_q     <= '0;
      half_q     <= '0;
      gap_q      <= '0;
      phase_q    <= 1'b0;
      spk_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus.stop && state_q != S_IDLE) begin
        state_q <= S_IDLE;
        spk_q   <= 1'b0;
        busy_q  <= 1'b0;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            spk_q <= 1'b0;
            if (bus.start && !bus.stop) begin
              addr_q  <= '0;
              busy_q  <= 1'b1;
              state_q <= S_FETCH;
            end
          end
          S_FETCH: state_q <= S_LOAD;
          S_LOAD: begin
            if (bus.rom_data[3:0] == 4'd0 || addr_q == ADDR_END) begin
              if (bus.loop_en) begin
                addr_q  <= '0;
                state_q <= S_FETCH;
              end else begin
                done_q  <= 1'b1;
                state_q <= S_DONE;
              end
            end else begin
              note_idx_q <= addr_q[ADDR_W-1:0];
              ticks_q    <= bus.rom_data[3:0];
              half_q     <= half_period(bus.rom_data[7:4]);
              tone_q     <= half_period(bus.rom_data[7:4]);
              presc_q    <= '0;
              phase_q    <= 1'b0;
              spk_q      <= 1'b0;
              state_q    <= S_PLAY;
            end
          end
          S_PLAY: begin
            // phase_q keeps the tone phase across a pause; spk_q is the gated copy.
            if (bus.pause) begin
              spk_q <= 1'b0;
            end else begin
              if (half_q != 15'd0 && tone_q == 15'd1) begin
                tone_q  <= half_q;
                phase_q <= ~phase_q;
                spk_q   <= ~phase_q;
              end else begin
                if (half_q != 15'd0) tone_q <= tone_q - 15'd1;
                spk_q <= phase_q;
              end
              if (presc_q == PRESC_LAST) begin
                presc_q <= '0;
                ticks_q <= ticks_q - 4'd1;
                if (ticks_q == 4'd1) begin
                  spk_q   <= 1'b0;
                  addr_q  <= addr_q + 1'b1;
                  gap_q   <= '0;
                  state_q <= (GAP_CYC == 0) ? S_FETCH : S_GAP;
                end
              end else begin
                presc_q <= presc_q + 1'b1;
              end
            end
          end
          S_GAP: begin
            spk_q <= 1'b0;
            if (!bus.pause) begin
              if (gap_q == GAP_LAST) state_q <= S_FETCH;
              else gap_q <= gap_q + 1'b1;
            end
          end
          S_DONE: begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.rom_addr    = addr_q[ADDR_W-1:0];
  assign bus.speaker_out = spk_q;
  assign bus.busy        = busy_q;
  assign bus.note_idx    = note_idx_q;
  assign bus.done        = done_q;
  assign bus.state_dbg   = state_q;

endmodule
